// File: rtl/waveform_mode_ctrl_if.sv
// rtl/waveform_mode_ctrl_if.sv - key/mode bundle for the waveform mode selector
// Purpose: groups the per-channel key inputs and the packed mode outputs.
// Signals:
//   key_next[NUM_CH]        forward step key per channel (level, synchronised)
//   key_prev[NUM_CH]        backward step key per channel (level, synchronised)
//   key_off[NUM_CH]         force-OFF key per channel (level, synchronised)
//   mode[NUM_CH*MODE_W]     packed mode indices, channel c at [c*MODE_W +: MODE_W]
//   mode_changed[NUM_CH]    one-cycle strobe when a channel's mode changes
// Modports: master drives keys and observes modes; slave is the selector.
interface waveform_mode_ctrl_if #(
    parameter int NUM_CH    = 2,
    parameter int NUM_MODES = 4
);
    localparam int MODE_W = $clog2(NUM_MODES);

    logic [NUM_CH-1:0]        key_next;
    logic [NUM_CH-1:0]        key_prev;
    logic [NUM_CH-1:0]        key_off;
    logic [NUM_CH*MODE_W-1:0] mode;
    logic [NUM_CH-1:0]        mode_changed;

    modport master (
        output key_next,
        output key_prev,
        output key_off,
        input  mode,
        input  mode_changed
    );

    modport slave (
        input  key_next,
        input  key_prev,
        input  key_off,
        output mode,
        output mode_changed
    );
endinterface

// File: rtl/waveform_mode_ctrl.sv
// rtl/waveform_mode_ctrl.sv - per-channel waveform mode stepper driven by key edges
// Purpose: each channel holds a mode index 0..NUM_MODES-1 (0 = OFF), stepped
//   forward/back with wrap-around on key rising edges, or forced to OFF.
// Ports:
//   clk     in   system clock, rising edge
//   n_rst   in   asynchronous active-low reset
//   bus     slave modport of waveform_mode_ctrl_if (keys in, mode/mode_changed out)
// Optional: define WAVE_MODE_LOCKOUT_EN to ignore next/prev rises for
//   LOCKOUT_CYCLES cycles after each mode change on that channel.
module waveform_mode_ctrl #(
    parameter int NUM_CH         = 2,
    parameter int NUM_MODES      = 4,
    parameter int LOCKOUT_CYCLES = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    waveform_mode_ctrl_if.slave bus
);
    localparam int              MODE_W   = $clog2(NUM_MODES);
    localparam logic [MODE_W-1:0] MODE_MAX = MODE_W'(NUM_MODES - 1);

    if (NUM_CH < 1 || NUM_MODES < 2 || LOCKOUT_CYCLES < 1) begin : g_param_check
        $error("waveform_mode_ctrl: illegal parameter value");
    end

    logic [NUM_CH-1:0]        next_q;
    logic [NUM_CH-1:0]        prev_q;
    logic [NUM_CH-1:0]        off_q;
    logic [NUM_CH-1:0]        next_rise;
    logic [NUM_CH-1:0]        prev_rise;
    logic [NUM_CH-1:0]        off_rise;
    logic [NUM_CH-1:0]        step_ok;
    logic [NUM_CH*MODE_W-1:0] mode_r;
    logic [NUM_CH*MODE_W-1:0] mode_nxt;
    logic [NUM_CH-1:0]        changed_r;
    logic [NUM_CH-1:0]        changed_nxt;

    // Key history resets high so a key held through reset release is not an event.
    assign next_rise = bus.key_next & ~next_q;
    assign prev_rise = bus.key_prev & ~prev_q;
    assign off_rise  = bus.key_off  & ~off_q;

`ifdef WAVE_MODE_LOCKOUT_EN
    localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

    logic [LOCK_W-1:0] lock_cnt [NUM_CH];

    always_comb begin
        step_ok = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            step_ok[c] = (lock_cnt[c] == '0);
        end
    end

    // Loaded on any real change (including force-OFF); only next/prev honour it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                lock_cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (changed_nxt[c]) begin
                    lock_cnt[c] <= LOCK_W'(LOCKOUT_CYCLES);
                end else if (lock_cnt[c] != '0) begin
                    lock_cnt[c] <= lock_cnt[c] - LOCK_W'(1);
                end
            end
        end
    end
`else
    assign step_ok = '1;
`endif

    always_comb begin
        logic [MODE_W-1:0] cur;
        logic [MODE_W-1:0] cand;
        cur         = '0;
        cand        = '0;
        mode_nxt    = mode_r;
        changed_nxt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            cur  = mode_r[c*MODE_W +: MODE_W];
            cand = cur;
            if (off_rise[c]) begin
                cand = '0;
            end else if (step_ok[c] && next_rise[c] && !prev_rise[c]) begin
                // Explicit compare keeps non-power-of-two mode counts in range.
                cand = (cur == MODE_MAX) ? '0 : cur + MODE_W'(1);
            end else if (step_ok[c] && prev_rise[c] && !next_rise[c]) begin
                cand = (cur == '0) ? MODE_MAX : cur - MODE_W'(1);
            end
            mode_nxt[c*MODE_W +: MODE_W] = cand;
            changed_nxt[c]               = (cand != cur);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            next_q    <= '1;
            prev_q    <= '1;
            off_q     <= '1;
            mode_r    <= '0;
            changed_r <= '0;
        end else begin
            next_q    <= bus.key_next;
            prev_q    <= bus.key_prev;
            off_q     <= bus.key_off;
            mode_r    <= mode_nxt;
            changed_r <= changed_nxt;
        end
    end

    assign bus.mode         = mode_r;
    assign bus.mode_changed = changed_r;
endmodule

// File: tb/tb_waveform_mode_ctrl.sv
// tb/tb_waveform_mode_ctrl.sv - directed scoreboard bench for waveform_mode_ctrl
module tb_waveform_mode_ctrl;
    logic clk = 1'b0;
    logic n_rst;

    always #5 clk = ~clk;

    waveform_mode_ctrl_if #(.NUM_CH(2), .NUM_MODES(4)) bus4 ();
    waveform_mode_ctrl_if #(.NUM_CH(2), .NUM_MODES(3)) bus3 ();

    waveform_mode_ctrl #(.NUM_CH(2), .NUM_MODES(4), .LOCKOUT_CYCLES(4)) dut4 (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus4)
    );

    waveform_mode_ctrl #(.NUM_CH(2), .NUM_MODES(3), .LOCKOUT_CYCLES(4)) dut3 (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus3)
    );

    typedef struct packed {
        logic [3:0] m4;
        logic [1:0] c4;
        logic [3:0] m3;
        logic [1:0] c3;
    } exp_t;

    exp_t       sb_q[$];
    int         tests = 0;
    int         fails = 0;
    logic [3:0] cur4  = 4'h0;
    logic [3:0] cur3  = 4'h0;

    task automatic drive(input logic [1:0] nx, input logic [1:0] pv, input logic [1:0] of);
        bus4.key_next = nx;
        bus4.key_prev = pv;
        bus4.key_off  = of;
        bus3.key_next = nx;
        bus3.key_prev = pv;
        bus3.key_off  = of;
    endtask

    task automatic check_out(input string tag, input exp_t e);
        tests++;
        assert (bus4.mode === e.m4) else begin
            fails++;
            $error("FAIL %s mode4 got %b expected %b", tag, bus4.mode, e.m4);
        end
        tests++;
        assert (bus4.mode_changed === e.c4) else begin
            fails++;
            $error("FAIL %s chg4 got %b expected %b", tag, bus4.mode_changed, e.c4);
        end
        tests++;
        assert (bus3.mode === e.m3) else begin
            fails++;
            $error("FAIL %s mode3 got %b expected %b", tag, bus3.mode, e.m3);
        end
        tests++;
        assert (bus3.mode_changed === e.c3) else begin
            fails++;
            $error("FAIL %s chg3 got %b expected %b", tag, bus3.mode_changed, e.c3);
        end
    endtask

    // Drive one cycle of keys, queue the expected outputs, compare after the edge.
    task automatic step(input logic [1:0] nx, input logic [1:0] pv, input logic [1:0] of,
                        input logic [3:0] m4, input logic [1:0] c4,
                        input logic [3:0] m3, input logic [1:0] c3, input string tag);
        exp_t e;
        @(negedge clk);
        drive(nx, pv, of);
        e.m4 = m4;
        e.c4 = c4;
        e.m3 = m3;
        e.c3 = c3;
        sb_q.push_back(e);
        cur4 = m4;
        cur3 = m3;
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_out(tag, e);
    endtask

    // Idle cycles long enough for any lockout to expire.
    task automatic gap();
        repeat (4) step(2'b00, 2'b00, 2'b00, cur4, 2'b00, cur3, 2'b00, "gap");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t zero;
        zero  = '0;
        n_rst = 1'b0;
        drive(2'b00, 2'b00, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", zero);
        @(negedge clk);
        n_rst = 1'b1;

        step(2'b00, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b0000, 2'b00, "idle");

        // Four pulses on next[0]: 4-mode wraps 3->0, 3-mode wraps 2->0.
        step(2'b01, 2'b00, 2'b00, 4'b0001, 2'b01, 4'b0001, 2'b01, "next1");
        step(2'b00, 2'b00, 2'b00, 4'b0001, 2'b00, 4'b0001, 2'b00, "rel1");
        gap();
        step(2'b01, 2'b00, 2'b00, 4'b0010, 2'b01, 4'b0010, 2'b01, "next2");
        step(2'b00, 2'b00, 2'b00, 4'b0010, 2'b00, 4'b0010, 2'b00, "rel2");
        gap();
        step(2'b01, 2'b00, 2'b00, 4'b0011, 2'b01, 4'b0000, 2'b01, "next3");
        step(2'b00, 2'b00, 2'b00, 4'b0011, 2'b00, 4'b0000, 2'b00, "rel3");
        gap();
        step(2'b01, 2'b00, 2'b00, 4'b0000, 2'b01, 4'b0001, 2'b01, "next4");
        step(2'b00, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b0001, 2'b00, "rel4");
        gap();

        // prev[1] from 0 wraps to the top mode.
        step(2'b00, 2'b10, 2'b00, 4'b1100, 2'b10, 4'b1001, 2'b10, "prev_wrap");
        step(2'b00, 2'b00, 2'b00, 4'b1100, 2'b00, 4'b1001, 2'b00, "rel_prev");
        gap();

        // Held key: exactly one event.
        step(2'b01, 2'b00, 2'b00, 4'b1101, 2'b01, 4'b1010, 2'b01, "hold_first");
        repeat (9) step(2'b01, 2'b00, 2'b00, 4'b1101, 2'b00, 4'b1010, 2'b00, "hold");
        step(2'b00, 2'b00, 2'b00, 4'b1101, 2'b00, 4'b1010, 2'b00, "hold_rel");
        gap();

        // next and prev together cancel.
        step(2'b01, 2'b01, 2'b00, 4'b1101, 2'b00, 4'b1010, 2'b00, "next_prev");
        step(2'b00, 2'b00, 2'b00, 4'b1101, 2'b00, 4'b1010, 2'b00, "rel_np");
        step(2'b01, 2'b00, 2'b00, 4'b1110, 2'b01, 4'b1000, 2'b01, "to_mode2");
        step(2'b00, 2'b00, 2'b00, 4'b1110, 2'b00, 4'b1000, 2'b00, "rel_m2");
        gap();

        // off wins over next; off at 0 gives no strobe.
        step(2'b01, 2'b00, 2'b01, 4'b1100, 2'b01, 4'b1000, 2'b00, "off_next");
        step(2'b00, 2'b00, 2'b00, 4'b1100, 2'b00, 4'b1000, 2'b00, "rel_off");
        gap();

        // next[1] wrap on channel 1, channel 0 untouched.
        step(2'b10, 2'b00, 2'b00, 4'b0000, 2'b10, 4'b0000, 2'b10, "next_ch1");
        step(2'b00, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b0000, 2'b00, "rel_ch1");
        gap();

        // Climb to mode 3, then async reset with the key still held.
        step(2'b01, 2'b00, 2'b00, 4'b0001, 2'b01, 4'b0001, 2'b01, "climb1");
        step(2'b00, 2'b00, 2'b00, 4'b0001, 2'b00, 4'b0001, 2'b00, "crel1");
        gap();
        step(2'b01, 2'b00, 2'b00, 4'b0010, 2'b01, 4'b0010, 2'b01, "climb2");
        step(2'b00, 2'b00, 2'b00, 4'b0010, 2'b00, 4'b0010, 2'b00, "crel2");
        gap();
        step(2'b01, 2'b00, 2'b00, 4'b0011, 2'b01, 4'b0000, 2'b01, "climb3");
        #3;
        n_rst = 1'b0;
        #1;
        check_out("async_rst", zero);
        @(posedge clk);
        #1;
        check_out("in_rst", zero);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) step(2'b01, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b0000, 2'b00, "held_post_rst");
        step(2'b00, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b0000, 2'b00, "rst_release");
        step(2'b01, 2'b00, 2'b00, 4'b0001, 2'b01, 4'b0001, 2'b01, "repress");
        step(2'b00, 2'b00, 2'b00, 4'b0001, 2'b00, 4'b0001, 2'b00, "rel_repress");
        gap();

        // Presses at cycles 0, 2, 6, then off at cycle 7.
        step(2'b01, 2'b00, 2'b00, 4'b0010, 2'b01, 4'b0010, 2'b01, "lk_c0");
        step(2'b00, 2'b00, 2'b00, 4'b0010, 2'b00, 4'b0010, 2'b00, "lk_c1");
`ifdef WAVE_MODE_LOCKOUT_EN
        step(2'b01, 2'b00, 2'b00, 4'b0010, 2'b00, 4'b0010, 2'b00, "lk_c2");
        repeat (3) step(2'b00, 2'b00, 2'b00, 4'b0010, 2'b00, 4'b0010, 2'b00, "lk_idle");
        step(2'b01, 2'b00, 2'b00, 4'b0011, 2'b01, 4'b0000, 2'b01, "lk_c6");
        step(2'b00, 2'b00, 2'b01, 4'b0000, 2'b01, 4'b0000, 2'b00, "lk_off");
        step(2'b00, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b0000, 2'b00, "lk_c8");
`else
        step(2'b01, 2'b00, 2'b00, 4'b0011, 2'b01, 4'b0000, 2'b01, "lk_c2");
        repeat (3) step(2'b00, 2'b00, 2'b00, 4'b0011, 2'b00, 4'b0000, 2'b00, "lk_idle");
        step(2'b01, 2'b00, 2'b00, 4'b0000, 2'b01, 4'b0001, 2'b01, "lk_c6");
        step(2'b00, 2'b00, 2'b01, 4'b0000, 2'b00, 4'b0000, 2'b01, "lk_off");
        step(2'b00, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b0000, 2'b00, "lk_c8");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
